// File: rtl/ula_seq_ctrl.sv
// Four-state sequencer for the ULA datapath: accepts one instruction per
// handshake, steers register-file addresses, SrcB select and ALU op, and captures the zero flag.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an instruction, instr_ready high
// DECODE | read addresses driven, illegal opcode reported here
// EXEC   | ALU operands/op driven, zero flag captured at end of cycle
// WB     | result written back (unless CMP/CMPI/NOP), done pulse
module ula_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs1,
    input  logic [REG_AW-1:0] instr_rs2,
    input  logic [DATA_W-1:0] instr_imm,
    output logic [REG_AW-1:0] rf_ra1,
    output logic [REG_AW-1:0] rf_ra2,
    output logic [REG_AW-1:0] rf_wa,
    output logic              rf_we,
    output logic [DATA_W-1:0] constante,
    output logic              select_src,
    output logic [2:0]        alu_ctrl,
    input  logic              alu_zero,
    output logic              flag_z,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_EXEC   = 2'd2,
        S_WB     = 2'd3
    } state_t;

    localparam logic [3:0] OP_CMP     = 4'd6;
    localparam logic [3:0] OP_ILLEGAL = 4'd7;
    localparam logic [3:0] OP_CMPI    = 4'd14;
    localparam logic [3:0] OP_NOP     = 4'd15;

    state_t              state_q, state_d;
    logic [3:0]          op_q, op_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [REG_AW-1:0]   rs1_q, rs1_d;
    logic [REG_AW-1:0]   rs2_q, rs2_d;
    logic [DATA_W-1:0]   imm_q, imm_d;
    logic                flag_z_q, flag_z_d;

    logic                accept;
    logic                writes_rd;

    assign accept    = instr_valid && (state_q == S_IDLE);
    assign writes_rd = (op_q != OP_CMP) && (op_q != OP_CMPI) &&
                       (op_q != OP_NOP) && (op_q != OP_ILLEGAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            flag_z_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            flag_z_q <= flag_z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        flag_z_d = flag_z_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    imm_d   = instr_imm;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (op_q == OP_ILLEGAL) ? S_IDLE : S_EXEC;
            end
            S_EXEC: begin
                // NOP keeps the flag of the previous operation
                if (op_q != OP_NOP) begin
                    flag_z_d = alu_zero;
                end
                state_d = S_WB;
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath controls are held from DECODE through WB so the result is stable at write-back
    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        rf_we       = 1'b0;
        rf_ra1      = '0;
        rf_ra2      = '0;
        rf_wa       = '0;
        constante   = '0;
        select_src  = 1'b0;
        alu_ctrl    = '0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    instr_ready = 1'b1;
                end
                S_DECODE: begin
                    busy       = 1'b1;
                    rf_ra1     = rs1_q;
                    rf_ra2     = rs2_q;
                    constante  = imm_q;
                    select_src = op_q[3];
                    alu_ctrl   = op_q[2:0];
                    err        = (op_q == OP_ILLEGAL);
                end
                S_EXEC: begin
                    busy       = 1'b1;
                    rf_ra1     = rs1_q;
                    rf_ra2     = rs2_q;
                    constante  = imm_q;
                    select_src = op_q[3];
                    alu_ctrl   = op_q[2:0];
                end
                S_WB: begin
                    busy       = 1'b1;
                    rf_ra1     = rs1_q;
                    rf_ra2     = rs2_q;
                    constante  = imm_q;
                    select_src = op_q[3];
                    alu_ctrl   = op_q[2:0];
                    rf_wa      = rd_q;
                    rf_we      = writes_rd;
                    done       = 1'b1;
                end
                default: begin
                    instr_ready = 1'b0;
                end
            endcase
        end
    end

    assign flag_z = rst ? 1'b0 : flag_z_q;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl: a register-file/ALU stand-in closes the loop, and a
// scoreboard predicts each accepted instruction's timing, write-back and zero flag.
module tb_ula_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [3:0] instr_op;
    logic [2:0] instr_rd, instr_rs1, instr_rs2;
    logic [7:0] instr_imm;
    logic [2:0] rf_ra1, rf_ra2, rf_wa;
    logic       rf_we;
    logic [7:0] constante;
    logic       select_src;
    logic [2:0] alu_ctrl;
    logic       alu_zero;
    logic       flag_z, busy, done, err;

    ula_seq_ctrl #(.DATA_W(8), .REG_AW(3)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs1(instr_rs1),
        .instr_rs2(instr_rs2), .instr_imm(instr_imm),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_wa(rf_wa), .rf_we(rf_we),
        .constante(constante), .select_src(select_src), .alu_ctrl(alu_ctrl),
        .alu_zero(alu_zero), .flag_z(flag_z), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
        end
    endtask

    // ALU semantics of the datapath: SLT is signed, CMP subtracts without write-back
    function automatic logic [7:0] alu_fn(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 8'd1 : 8'd0;
            3'd6: return a - b;
            default: return 8'd0;
        endcase
    endfunction

    // Environment register file and ALU driven by the DUT's controls
    logic [7:0] regs_env [8];
    logic [7:0] alu_res;
    always_comb begin
        alu_res  = alu_fn(alu_ctrl, regs_env[rf_ra1], select_src ? constante : regs_env[rf_ra2]);
        alu_zero = (alu_res == 8'd0);
    end

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm, result, old_val;
        bit         legal, we, flag_after;
        int         dec_cyc, fin_cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mregs [8];
    bit         mflag = 1'b0;
    int         free_at = 0;
    bit         prev_rst = 1'b0;

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = 8'($urandom);
        mregs[1] = 8'h0A;
        mregs[4] = 8'h33;
        mregs[5] = 8'h33;
        mregs[6] = 8'h7F;
        for (int i = 0; i < 8; i++) regs_env[i] = mregs[i];
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("outs_in_reset", 32'({instr_ready, busy, done, err, rf_we, select_src, flag_z}), 32'd0);
                chk("buses_in_reset", 32'({rf_ra1, rf_ra2, rf_wa, alu_ctrl, constante}), 32'd0);
                while (q.size() > 0) begin
                    if (q[$].we) mregs[q[$].rd] = q[$].old_val;
                    void'(q.pop_back());
                end
                mflag    = 1'b0;
                free_at  = cyc + 1;
                prev_rst = 1'b1;
            end else begin
                bit have, at;
                have = (q.size() > 0);
                at   = have && (cyc == q[0].fin_cyc);
                if (prev_rst)
                    chk("post_reset_idle", 32'({busy, done, err, rf_we, flag_z}), 32'd0);
                chk("instr_ready", 32'(instr_ready), 32'(cyc >= free_at));
                chk("busy", 32'(busy), 32'(have));
                chk("done", 32'(done), 32'(at && q[0].legal));
                chk("err", 32'(err), 32'(at && !q[0].legal));
                chk("rf_we", 32'(rf_we), 32'(at && q[0].we));
                if (have && cyc == q[0].dec_cyc) begin
                    chk("decode_ra1", 32'(rf_ra1), 32'(q[0].rs1));
                    chk("decode_ra2", 32'(rf_ra2), 32'(q[0].rs2));
                end
                if (have && q[0].legal && cyc == q[0].dec_cyc + 1) begin
                    chk("exec_select_src", 32'(select_src), 32'(q[0].op[3]));
                    chk("exec_alu_ctrl", 32'(alu_ctrl), 32'(q[0].op[2:0]));
                    chk("exec_constante", 32'(constante), 32'(q[0].imm));
                    chk("exec_ra1", 32'(rf_ra1), 32'(q[0].rs1));
                    if (!q[0].op[3]) chk("exec_ra2", 32'(rf_ra2), 32'(q[0].rs2));
                end
                if (at) begin
                    chk("flag_z", 32'(flag_z), 32'(q[0].flag_after));
                    if (q[0].legal) chk("wb_rf_wa", 32'(rf_wa), 32'(q[0].rd));
                    if (q[0].we) chk("wb_result", 32'(alu_res), 32'(q[0].result));
                end
                if (rf_we) regs_env[rf_wa] = alu_res;
                if (at) void'(q.pop_front());
                if (instr_valid && instr_ready) begin
                    exp_t e;
                    logic [7:0] b;
                    e.op      = instr_op;
                    e.rd      = instr_rd;
                    e.rs1     = instr_rs1;
                    e.rs2     = instr_rs2;
                    e.imm     = instr_imm;
                    e.legal   = (instr_op != 4'd7);
                    e.we      = e.legal && !(instr_op inside {4'd6, 4'd14, 4'd15});
                    b         = instr_op[3] ? instr_imm : mregs[instr_rs2];
                    e.result  = alu_fn(instr_op[2:0], mregs[instr_rs1], b);
                    e.flag_after = (e.legal && instr_op != 4'd15) ? (e.result == 8'd0) : mflag;
                    e.old_val = mregs[instr_rd];
                    e.dec_cyc = cyc + 1;
                    e.fin_cyc = e.legal ? cyc + 3 : cyc + 1;
                    free_at   = e.legal ? cyc + 4 : cyc + 2;
                    if (e.we) mregs[instr_rd] = e.result;
                    mflag = e.flag_after;
                    q.push_back(e);
                end
                prev_rst = 1'b0;
            end
        end
    end

    task automatic set_fields(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic [7:0] imm);
        instr_op  = op;
        instr_rd  = rd;
        instr_rs1 = rs1;
        instr_rs2 = rs2;
        instr_imm = imm;
    endtask

    // Waits for the handshake; returns the cycle of the accepting edge's preceding negedge
    task automatic wait_accept(input string nm, output int c);
        bit got = 1'b0;
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (instr_valid && instr_ready && !rst) begin
                got = 1'b1;
                c   = cyc;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL accept_timeout %s: got no handshake, expected one within 40 cycles", nm);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2, input logic [7:0] imm);
        int c;
        @(posedge clk);
        #1;
        set_fields(op, rd, rs1, rs2, imm);
        instr_valid = 1'b1;
        wait_accept(nm, c);
        instr_valid = 1'b0;
        set_fields(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
    endtask

    initial begin
        int a1, a2, a3;
        rst         = 1'b1;
        instr_valid = 1'b0;
        set_fields(4'd0, 3'd0, 3'd0, 3'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        issue("addi", 4'd8, 3'd3, 3'd1, 3'd0, 8'h05);
        issue("sub", 4'd1, 3'd2, 3'd4, 3'd5, 8'h00);
        issue("cmpi", 4'd14, 3'd0, 3'd6, 3'd0, 8'h7F);
        issue("illegal", 4'd7, 3'd5, 3'd2, 3'd3, 8'hAA);
        issue("nop", 4'd15, 3'd7, 3'd1, 3'd2, 8'h00);

        // Held valid, fields swapped for the next instruction while one is in flight
        @(posedge clk);
        #1;
        set_fields(4'd0, 3'd4, 3'd1, 3'd3, 8'h11);
        instr_valid = 1'b1;
        wait_accept("b2b_1", a1);
        set_fields(4'd12, 3'd5, 3'd4, 3'd0, 8'h0F);
        wait_accept("b2b_2", a2);
        set_fields(4'd5, 3'd6, 3'd2, 3'd1, 8'h00);
        wait_accept("b2b_3", a3);
        instr_valid = 1'b0;
        chk("b2b_gap_1", 32'(a2 - a1), 32'd4);
        chk("b2b_gap_2", 32'(a3 - a2), 32'd4);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            rst         = ($urandom_range(0, 79) == 0);
            instr_valid = ($urandom_range(0, 2) != 0);
            set_fields(4'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
        end
        @(posedge clk);
        #1;
        rst         = 1'b0;
        instr_valid = 1'b0;
        repeat (6) @(posedge clk);

        // Reset during EXEC of ADD rd=1
        issue("add_interrupted", 4'd0, 3'd1, 3'd2, 3'd3, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        issue("add_after_reset", 4'd0, 3'd7, 3'd2, 3'd3, 8'h00);
        repeat (6) @(posedge clk);

        @(negedge clk);
        for (int i = 0; i < 8; i++) chk($sformatf("regfile_r%0d", i), 32'(regs_env[i]), 32'(mregs[i]));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
